// File: rtl/can_pkg.sv
// can_pkg: shared CAN controller types, bus levels and default bit counts.
//   Used by can_bit_sampler, can_ifs_tx and the receive-side detector.
package can_pkg;

   typedef enum logic [3:0] {
      WAIT_IDLE,
      BUS_IDLE,
      SOF,
      FRAME,
      ACK_SLOT,
      ACK_DELIM,
      EOF,
      IFS,
      SUSPEND
   } ifs_state_t;

   localparam logic RECESSIVE = 1'b1;
   localparam logic DOMINANT  = 1'b0;

   localparam int EOF_BITS_DEF     = 7;
   localparam int IFS_BITS_DEF     = 3;
   localparam int SUSPEND_BITS_DEF = 8;
   localparam int IDLE_BITS_DEF    = 11;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/can_ifs_tx_if.sv
// can_ifs_tx_if: bus between bit timing / frame logic and the interframe sequencer.
//   master drives txPoint, samplePulse, rateSelector, rxBit, frameDone, ackDrive,
//   sofReq, errPassive; slave (can_ifs_tx) drives dOut, txGrant, rxSof, busIdle,
//   ackErr, formErr, overloadDet.
interface can_ifs_tx_if;
   logic txPoint;
   logic samplePulse;
   logic rateSelector;
   logic rxBit;
   logic frameDone;
   logic ackDrive;
   logic sofReq;
   logic errPassive;
   logic dOut;
   logic txGrant;
   logic rxSof;
   logic busIdle;
   logic ackErr;
   logic formErr;
   logic overloadDet;

   modport master (
      output txPoint, samplePulse, rateSelector, rxBit, frameDone, ackDrive, sofReq, errPassive,
      input  dOut, txGrant, rxSof, busIdle, ackErr, formErr, overloadDet
   );

   modport slave (
      input  txPoint, samplePulse, rateSelector, rxBit, frameDone, ackDrive, sofReq, errPassive,
      output dOut, txGrant, rxSof, busIdle, ackErr, formErr, overloadDet
   );
endinterface

// File: rtl/can_bit_sampler.sv
// can_bit_sampler: turns sample-point pulses into one decided bit per bit time.
//   Ports: clk, resetN (sync, active-low), txPoint (bit start, restarts counting),
//   samplePulse, rateSelector (1 = 3-sample majority, 0 = single sample), rxBit,
//   bitValid (one-cycle pulse), bitVal (decided level).
module can_bit_sampler
   import can_pkg::*;
(
   input  logic clk,
   input  logic resetN,
   input  logic txPoint,
   input  logic samplePulse,
   input  logic rateSelector,
   input  logic rxBit,
   output logic bitValid,
   output logic bitVal
);

   logic [1:0] r_cnt;
   logic [1:0] r_smp;
   logic       r_valid;
   logic       r_val;
   logic [1:0] w_cnt;
   logic       w_last;

   // Count 3 means this bit is already decided; later pulses are ignored.
   assign w_cnt  = txPoint ? 2'd0 : r_cnt;
   assign w_last = rateSelector ? (w_cnt == 2'd2) : (w_cnt == 2'd0);

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_cnt   <= 2'd0;
         r_smp   <= 2'd0;
         r_valid <= 1'b0;
         r_val   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_cnt   <= w_cnt;
         if (samplePulse && w_cnt != 2'd3) begin
            r_smp[w_cnt[0]] <= rxBit;
            r_cnt           <= w_last ? 2'd3 : w_cnt + 2'd1;
            if (w_last) begin
               r_valid <= 1'b1;
               r_val   <= rateSelector ? majority3(r_smp[0], r_smp[1], rxBit) : rxBit;
            end
         end
      end
   end

   assign bitValid = r_valid;
   assign bitVal   = r_val;

endmodule

// File: rtl/can_ifs_tx.sv
// can_ifs_tx: transmit-side ACK/EOF/intermission sequencer and bus-idle / SOF arbiter.
//   Ports: clk, resetN (sync, active-low), bus (can_ifs_tx_if.slave):
//   inputs txPoint, samplePulse, rateSelector, rxBit, frameDone, ackDrive, sofReq,
//   errPassive; outputs dOut (registered TX line), txGrant, rxSof, busIdle,
//   ackErr, formErr, overloadDet.
//   Optional: define SUSPEND_TX_EN to add suspend-transmission after own frames
//   while error-passive.
module can_ifs_tx
   import can_pkg::*;
#(
   parameter int EOF_BITS     = EOF_BITS_DEF,
   parameter int IFS_BITS     = IFS_BITS_DEF,
   parameter int IDLE_BITS    = IDLE_BITS_DEF,
   parameter int CNT_W        = $clog2(IDLE_BITS + 1)
`ifdef SUSPEND_TX_EN
   ,
   parameter int SUSPEND_BITS = SUSPEND_BITS_DEF
`endif
)
(
   input  logic         clk,
   input  logic         resetN,
   can_ifs_tx_if.slave  bus
);

   ifs_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_dOut;
   logic             r_txGrant;
   logic             r_rxSof;
   logic             r_busIdle;
   logic             r_ackErr;
   logic             r_formErr;
   logic             r_overloadDet;
   logic             w_bitValid;
   logic             w_bitVal;
   logic [CNT_W-1:0] w_cntNext;
`ifdef SUSPEND_TX_EN
   logic             r_ownTx;
`endif

   can_bit_sampler u_sampler (
      .clk          (clk),
      .resetN       (resetN),
      .txPoint      (bus.txPoint),
      .samplePulse  (bus.samplePulse),
      .rateSelector (bus.rateSelector),
      .rxBit        (bus.rxBit),
      .bitValid     (w_bitValid),
      .bitVal       (w_bitVal)
   );

   // w_cntNext is the 1-based index of the bit currently being decided.
   assign w_cntNext = r_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state       <= WAIT_IDLE;
         r_cnt         <= '0;
         r_dOut        <= RECESSIVE;
         r_txGrant     <= 1'b0;
         r_rxSof       <= 1'b0;
         r_busIdle     <= 1'b0;
         r_ackErr      <= 1'b0;
         r_formErr     <= 1'b0;
         r_overloadDet <= 1'b0;
`ifdef SUSPEND_TX_EN
         r_ownTx       <= 1'b0;
`endif
      end else begin
         r_txGrant     <= 1'b0;
         r_rxSof       <= 1'b0;
         r_ackErr      <= 1'b0;
         r_formErr     <= 1'b0;
         r_overloadDet <= 1'b0;
         // The granting txPoint itself already starts the dominant SOF bit.
         if (bus.txPoint)
            r_dOut <= ((r_state == ACK_SLOT && bus.ackDrive) || r_state == SOF ||
                       (r_state == BUS_IDLE && bus.sofReq)) ? DOMINANT : RECESSIVE;
         case (r_state)
            WAIT_IDLE:
               if (w_bitValid) begin
                  if (w_bitVal == DOMINANT)
                     r_cnt <= '0;
                  else if (w_cntNext == CNT_W'(IDLE_BITS)) begin
                     r_cnt     <= '0;
                     r_state   <= BUS_IDLE;
                     r_busIdle <= 1'b1;
                  end else
                     r_cnt <= w_cntNext;
               end
            BUS_IDLE:
               if (bus.txPoint && bus.sofReq) begin
                  r_state   <= SOF;
                  r_txGrant <= 1'b1;
                  r_busIdle <= 1'b0;
               end else if (w_bitValid && w_bitVal == DOMINANT) begin
                  r_state   <= FRAME;
                  r_rxSof   <= 1'b1;
                  r_busIdle <= 1'b0;
               end
            SOF:
               if (w_bitValid)
                  r_state <= FRAME;
            FRAME:
               if (bus.frameDone)
                  r_state <= ACK_SLOT;
            ACK_SLOT: begin
               r_cnt <= '0;
               if (w_bitValid) begin
`ifdef SUSPEND_TX_EN
                  r_ownTx <= !bus.ackDrive;
`endif
                  if (!bus.ackDrive && w_bitVal == RECESSIVE) begin
                     r_ackErr <= 1'b1;
                     r_state  <= WAIT_IDLE;
                  end else
                     r_state <= ACK_DELIM;
               end
            end
            ACK_DELIM: begin
               r_cnt <= '0;
               if (w_bitValid) begin
                  if (w_bitVal == DOMINANT) begin
                     r_formErr <= 1'b1;
                     r_state   <= WAIT_IDLE;
                  end else
                     r_state <= EOF;
               end
            end
            EOF:
               if (w_bitValid) begin
                  if (w_bitVal == DOMINANT) begin
                     r_cnt   <= '0;
                     r_state <= WAIT_IDLE;
                     if (w_cntNext == CNT_W'(EOF_BITS))
                        r_overloadDet <= 1'b1;
                     else
                        r_formErr <= 1'b1;
                  end else if (w_cntNext == CNT_W'(EOF_BITS)) begin
                     r_cnt   <= '0;
                     r_state <= IFS;
                  end else
                     r_cnt <= w_cntNext;
               end
            IFS:
               if (w_bitValid) begin
                  if (w_bitVal == DOMINANT) begin
                     r_cnt <= '0;
                     if (w_cntNext == CNT_W'(IFS_BITS)) begin
                        r_rxSof <= 1'b1;
                        r_state <= FRAME;
                     end else begin
                        r_overloadDet <= 1'b1;
                        r_state       <= WAIT_IDLE;
                     end
                  end else if (w_cntNext == CNT_W'(IFS_BITS)) begin
                     r_cnt <= '0;
`ifdef SUSPEND_TX_EN
                     if (bus.errPassive && r_ownTx)
                        r_state <= SUSPEND;
                     else begin
                        r_state   <= BUS_IDLE;
                        r_busIdle <= 1'b1;
                     end
`else
                     r_state   <= BUS_IDLE;
                     r_busIdle <= 1'b1;
`endif
                  end else
                     r_cnt <= w_cntNext;
               end
`ifdef SUSPEND_TX_EN
            SUSPEND:
               if (w_bitValid) begin
                  if (w_bitVal == DOMINANT) begin
                     r_cnt   <= '0;
                     r_rxSof <= 1'b1;
                     r_state <= FRAME;
                  end else if (w_cntNext == CNT_W'(SUSPEND_BITS)) begin
                     r_cnt     <= '0;
                     r_state   <= BUS_IDLE;
                     r_busIdle <= 1'b1;
                  end else
                     r_cnt <= w_cntNext;
               end
`endif
            default: begin
               r_cnt   <= '0;
               r_state <= WAIT_IDLE;
            end
         endcase
      end
   end

   assign bus.dOut        = r_dOut;
   assign bus.txGrant     = r_txGrant;
   assign bus.rxSof       = r_rxSof;
   assign bus.busIdle     = r_busIdle;
   assign bus.ackErr      = r_ackErr;
   assign bus.formErr     = r_formErr;
   assign bus.overloadDet = r_overloadDet;

endmodule

// File: tb/tb_can_ifs_tx.sv
// tb_can_ifs_tx: directed self-checking bench for can_ifs_tx.
module tb_can_ifs_tx;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   always #5 clk = ~clk;

   can_ifs_tx_if bus();

   can_ifs_tx dut (
      .clk    (clk),
      .resetN (resetN),
      .bus    (bus.slave)
   );

   int checks = 0;
   int failures = 0;
   int n_ack = 0, n_form = 0, n_ovl = 0, n_rxsof = 0, n_dlow = 0;
   int base;
   logic last_dout, last_grant;

   always @(negedge clk) begin
      if (bus.ackErr === 1'b1) n_ack++;
      if (bus.formErr === 1'b1) n_form++;
      if (bus.overloadDet === 1'b1) n_ovl++;
      if (bus.rxSof === 1'b1) n_rxsof++;
      if (bus.dOut === 1'b0) n_dlow++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bit time: txPoint, then 3 or 1 sample pulses; returns after any
   // resulting pulse has been seen and cleared.
   task automatic bit3(input logic a, input logic b, input logic c);
      bus.txPoint = 1'b1;
      @(negedge clk);
      last_dout  = bus.dOut;
      last_grant = bus.txGrant;
      bus.txPoint = 1'b0;
      @(negedge clk);
      for (int i = 0; i < (bus.rateSelector ? 3 : 1); i++) begin
         bus.rxBit = (i == 0) ? a : (i == 1) ? b : c;
         bus.samplePulse = 1'b1;
         @(negedge clk);
         bus.samplePulse = 1'b0;
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic bitv(input logic v);
      bit3(v, v, v);
   endtask

   task automatic bits(input int n, input logic v);
      repeat (n) bitv(v);
   endtask

   task automatic frame_done();
      bus.frameDone = 1'b1;
      @(negedge clk);
      bus.frameDone = 1'b0;
      @(negedge clk);
   endtask

   task automatic foreign_frame();
      bitv(1'b0);
      bits(3, 1'b1);
      frame_done();
   endtask

   initial begin
      bus.txPoint = 0; bus.samplePulse = 0; bus.rateSelector = 1; bus.rxBit = 1;
      bus.frameDone = 0; bus.ackDrive = 0; bus.sofReq = 0; bus.errPassive = 0;
      repeat (3) @(negedge clk);
      chk("rst_dout", bus.dOut, 1);
      chk("rst_busidle", bus.busIdle, 0);
      chk("rst_pulses", {bus.txGrant, bus.rxSof, bus.ackErr, bus.formErr, bus.overloadDet}, 0);
      resetN = 1'b1;
      @(negedge clk);

      bits(10, 1'b1);
      chk("idle_10", bus.busIdle, 0);
      bitv(1'b1);
      chk("idle_11", bus.busIdle, 1);
      chk("idle_dout_high", n_dlow, 0);

      // own frame, acknowledged, clean EOF/IFS
      bus.sofReq = 1'b1;
      bitv(1'b0);
      bus.sofReq = 1'b0;
      chk("sof_grant", last_grant, 1);
      chk("sof_dout", last_dout, 0);
      chk("sof_left_idle", bus.busIdle, 0);
      bits(3, 1'b1);
      chk("frame_dout", last_dout, 1);
      frame_done();
      bitv(1'b0);
      chk("ack_tx_dout", last_dout, 1);
      bits(8, 1'b1);
      bits(2, 1'b1);
      chk("ifs_2_not_idle", bus.busIdle, 0);
      bitv(1'b1);
      chk("ifs_done_idle", bus.busIdle, 1);
      chk("clean_no_errs", n_ack + n_form + n_ovl, 0);
      chk("clean_no_rxsof", n_rxsof, 0);

      // ACK error on own frame
      foreign_frame();
      chk("foreign_rxsof", n_rxsof, 1);
      bitv(1'b1);
      chk("ack_err", n_ack, 1);
      bits(10, 1'b1);
      chk("ackerr_wait_10", bus.busIdle, 0);
      bitv(1'b1);
      chk("ackerr_wait_11", bus.busIdle, 1);

      // receiver drives ACK, form error at EOF bit 3
      bus.ackDrive = 1'b1;
      foreign_frame();
      bitv(1'b0);
      chk("ack_rx_dout", last_dout, 0);
      bitv(1'b1);
      chk("delim_dout", last_dout, 1);
      bits(2, 1'b1);
      bitv(1'b0);
      chk("eof3_form", n_form, 1);
      chk("eof3_no_ovl", n_ovl, 0);
      bits(11, 1'b1);

      // dominant last EOF bit -> overload
      foreign_frame();
      bitv(1'b0);
      bits(7, 1'b1);
      bitv(1'b0);
      chk("eof7_ovl", n_ovl, 1);
      chk("eof7_no_form", n_form, 1);
      bits(11, 1'b1);

      // dominant last IFS bit -> foreign SOF
      foreign_frame();
      bitv(1'b0);
      bits(8, 1'b1);
      bits(2, 1'b1);
      base = n_rxsof;
      bitv(1'b0);
      chk("ifs3_rxsof", n_rxsof, base + 1);
      chk("ifs3_not_idle", bus.busIdle, 0);
      frame_done();
      bitv(1'b0);
      chk("ifs3_frame_ack", last_dout, 0);
      bits(11, 1'b1);
      chk("ifs3_back_idle", bus.busIdle, 1);

      // own frame while error-passive
      bus.ackDrive = 1'b0;
      bus.errPassive = 1'b1;
      bus.sofReq = 1'b1;
      bitv(1'b0);
      bus.sofReq = 1'b0;
      bits(3, 1'b1);
      frame_done();
      bitv(1'b0);
      bits(11, 1'b1);
`ifdef SUSPEND_TX_EN
      chk("susp_start", bus.busIdle, 0);
      bits(7, 1'b1);
      chk("susp_7", bus.busIdle, 0);
      bitv(1'b1);
      chk("susp_8_idle", bus.busIdle, 1);
`else
      chk("nosusp_idle", bus.busIdle, 1);
`endif
      bus.errPassive = 1'b0;

      // majority in 3-sample mode
      base = n_rxsof;
      bit3(1'b0, 1'b1, 1'b1);
      chk("maj_011_idle", bus.busIdle, 1);
      chk("maj_011_no_sof", n_rxsof, base);
      bit3(1'b1, 1'b0, 1'b0);
      chk("maj_100_sof", n_rxsof, base + 1);
      chk("maj_100_busy", bus.busIdle, 0);

      // 1-sample mode
      bus.rateSelector = 1'b0;
      bus.ackDrive = 1'b1;
      frame_done();
      bitv(1'b0);
      bits(11, 1'b1);
      chk("one_smp_idle", bus.busIdle, 1);
      base = n_rxsof;
      bit3(1'b0, 1'b1, 1'b1);
      chk("one_smp_sof", n_rxsof, base + 1);

      // reset in the middle of EOF
      frame_done();
      bitv(1'b0);
      chk("pre_rst_ack_dout", last_dout, 0);
      bits(3, 1'b1);
      base = n_form + n_ovl;
      resetN = 1'b0;
      @(negedge clk);
      chk("midrst_dout", bus.dOut, 1);
      chk("midrst_busidle", bus.busIdle, 0);
      resetN = 1'b1;
      bits(10, 1'b1);
      chk("midrst_wait_10", bus.busIdle, 0);
      bitv(1'b1);
      chk("midrst_wait_11", bus.busIdle, 1);
      chk("midrst_no_errs", n_form + n_ovl, base);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/can_ifs_tx.md
Name: can_ifs_tx

Overview:
- Transmit-side end-of-frame and interframe sequencer for the CAN controller.
- After each frame body (through the CRC delimiter), it drives the ACK slot and ACK delimiter, 7 EOF bits and 3 intermission bits on the TX line, and checks the sampled bus during each of those bits.
- It grants start-of-frame (SOF) to the host, or flags an incoming SOF, once the bus is idle.
- Sits between the bit-timing unit (txPoint/samplePulse) and the frame serializer/deserializer.

Parameters:
- EOF_BITS, 7, recessive end-of-frame bit count
- IFS_BITS, 3, intermission bit count
- SUSPEND_BITS, 8, suspend-transmission bit count (only with SUSPEND_TX_EN)
- IDLE_BITS, 11, consecutive recessive bits required for bus integration
- CNT_W, $clog2(IDLE_BITS+1), bit counter width

Ports:
- clk  in  1  clock
- resetN  in  1  synchronous active-low reset
- txPoint  in  1  one-cycle pulse at start of each bit time
- samplePulse  in  1  sample-point pulse; 3 per bit when rateSelector=1, 1 per bit when rateSelector=0
- rateSelector  in  1  1 = 3-sample mode, 0 = 1-sample mode
- rxBit  in  1  synchronized bus level (0 = dominant)
- frameDone  in  1  pulse: CRC delimiter bit finished (own TX or RX frame)
- ackDrive  in  1  1 = node is receiver with good CRC (drive dominant ACK); 0 = node is transmitter (send recessive, expect dominant)
- sofReq  in  1  level: host has a frame pending
- errPassive  in  1  node is error-passive
- dOut  out  1  TX line, registered
- txGrant  out  1  pulse: this node drives SOF now
- rxSof  out  1  pulse: foreign SOF detected
- busIdle  out  1  level: BUS_IDLE state
- ackErr  out  1  pulse
- formErr  out  1  pulse
- overloadDet  out  1  pulse

Behaviour:
- Reset (clk edge with resetN=0), also when asserted mid-operation: state WAIT_IDLE, counter 0, dOut=1, busIdle=0, all pulses 0, sampler cleared.
- Sampler (sub-module) emits bitValid for one cycle with bitVal:
  - rateSelector=1: after the 3rd samplePulse of the bit; bitVal = majority of the 3 samples.
  - rateSelector=0: after the 1st samplePulse; bitVal = that sample.
  - The sampler's pulse count resets on txPoint.
- State advances only on bitValid.
- dOut is registered on txPoint from the state at that cycle:
  - dOut=0 in ACK_SLOT when ackDrive=1, and in SOF.
  - dOut=1 in all other cases.
- States and transitions:
  - WAIT_IDLE: count recessive bitVal. A dominant bit clears the counter. Counter reaching IDLE_BITS -> BUS_IDLE.
  - BUS_IDLE (busIdle=1):
    - txPoint with sofReq=1 -> SOF; txGrant pulses that cycle; dOut=0.
    - Otherwise, dominant bitVal -> FRAME with rxSof pulse.
    - If txPoint with sofReq and a dominant bitVal coincide in one cycle, txPoint/SOF wins.
  - SOF: on bitValid -> FRAME.
  - FRAME: wait for frameDone -> ACK_SLOT. frameDone in any other state is ignored.
  - ACK_SLOT: when ackDrive=0 and bitVal=1, pulse ackErr and go to WAIT_IDLE. Otherwise -> ACK_DELIM.
  - ACK_DELIM: bitVal=0 -> formErr, WAIT_IDLE. Otherwise -> EOF with counter=0.
  - EOF: counter increments on each bitValid.
    - Dominant at EOF bits 1..EOF_BITS-1 -> formErr, WAIT_IDLE.
    - Dominant at the last EOF bit -> overloadDet, WAIT_IDLE.
    - Recessive last bit -> IFS.
  - IFS:
    - Dominant at bits 1..IFS_BITS-1 -> overloadDet, WAIT_IDLE.
    - Dominant at the last bit -> rxSof, FRAME.
    - Recessive last bit -> SUSPEND when SUSPEND_TX_EN is defined and errPassive=1 and the completed frame was own TX (ackDrive=0, latched at ACK_SLOT); otherwise -> BUS_IDLE.
  - SUSPEND: dominant bit -> rxSof, FRAME. After SUSPEND_BITS recessive bits -> BUS_IDLE. sofReq is ignored here.
- Pulses are exactly one clk wide. At most one error pulse per bit.
- Counter never exceeds IDLE_BITS. No wrap.

Optional Feature:
- SUSPEND_TX_EN.
  - Defined: SUSPEND state and errPassive are honoured.
  - Undefined: the SUSPEND state is not compiled, errPassive is unused, and IFS always goes to BUS_IDLE.

Decomposition:
- Shared package can_pkg holds:
  - ifs_state_t enum (WAIT_IDLE, BUS_IDLE, SOF, FRAME, ACK_SLOT, ACK_DELIM, EOF, IFS, SUSPEND)
  - constants RECESSIVE=1'b1, DOMINANT=1'b0
  - default bit counts
- Sub-module can_bit_sampler (samplePulse/rateSelector/txPoint -> bitValid, bitVal) is reusable by the receive-side detector.

Test Plan:
- Reset, then 11 recessive bits in 3-sample mode -> busIdle=1 after the 11th bitValid; dOut=1 throughout.
- BUS_IDLE, sofReq=1 -> txGrant at the next txPoint; dOut=0 for one bit; then FRAME. frameDone with ackDrive=0, dominant ACK, 7+3 recessive bits -> busIdle returns; no error pulses.
- ackDrive=0, recessive ACK slot -> ackErr pulse, WAIT_IDLE. ackDrive=1 -> dOut=0 during the ACK bit only.
- Dominant at EOF bit 3 -> formErr. Dominant at EOF bit 7 -> overloadDet. Dominant at IFS bit 3 -> rxSof, FRAME.
- SUSPEND_TX_EN, errPassive=1, own TX -> busIdle asserts 8 bits after IFS ends. Without the macro -> busIdle asserts immediately after IFS ends.
- 1-sample mode with a glitch sample pattern 0,1,1 in 3-sample mode -> majority yields recessive. Assert resetN=0 mid-EOF -> dOut=1 and WAIT_IDLE next cycle.
